pc_gen_ras: RTL
===============

// Module: pc_gen_ras
// PURPOSE
//  Next-generation program-counter unit for the MIPS-style core; sits between the control unit and instruction memory.
//  Adds the following to the basic PC-select register:
//   - stall/hold
//   - a kernel-mode bit (PC MSB) with protection rules
//   - an EPC register captured on exceptions and interrupts
//   - a return-address stack (RAS) that predicts function returns
//  Parametrised in address width, exception vectors and RAS depth.
// PARAMETERS
//  XLEN       32            PC/data width (>=32); MSB is the kernel bit
//  RESET_PC   32'h80000000  PC after reset (kernel entry)
//  ILLOP_VEC  32'h80000004  illegal-instruction / interrupt vector
//  XADR_VEC   32'h80000008  exception vector
//  RAS_DEPTH  4             return-stack entries, power of 2, >=2
// PORTS
//  clk         in   1          clock, rising edge
//  reset       in   1          synchronous, active-low
//  stall       in   1          1 = hold PC, EPC and RAS this cycle
//  pc_src      in   3          next-PC select (see BEHAVIOUR)
//  br_taken    in   1          ALU branch condition, used when pc_src=001
//  ext_imm     in   XLEN       sign-extended branch offset, in words
//  jt          in   26         jump target field
//  reg_target  in   XLEN       register value for jr; also the fallback for the RAS
//  link        in   1          push plus4 onto RAS on jump (010/011)
//  irq         in   1          external interrupt request, level
//  pc          out  XLEN       current PC
//  plus4       out  XLEN       {pc[XLEN-1], pc[XLEN-2:0]+4}, combinational
//  epc         out  XLEN       exception return address
//  ras_top     out  XLEN       RAS top entry (undefined when empty)
//  ras_empty   out  1          RAS holds no valid entries
//  kernel      out  1          pc[XLEN-1]
// BEHAVIOUR
//  Reset (reset=0 at posedge): pc=RESET_PC, epc=0, RAS count=0, RAS pointer=0.
//   - Reset overrides all other inputs, including mid-stall and mid-IRQ.
//  Arithmetic:
//   - plus4 wraps within the low XLEN-1 bits and never alters the kernel bit.
//   - conba = {pc[MSB], (plus4 + {ext_imm[XLEN-3:0],2'b00})[XLEN-2:0]}
//   - jtgt  = {pc[XLEN-1:XLEN-4], jt, 2'b00}; for XLEN>32 zero-fill between.
//  Priority at each posedge: reset > stall > irq > pc_src.
//  IRQ:
//   - Taken only if irq=1, stall=0 and kernel=0.
//   - Effect: pc<=ILLOP_VEC and epc<=the value pc_src would have selected (next_pc).
//   - The RAS is not touched.
//  pc_src codes (next_pc):
//   000  plus4
//   001  br_taken ? conba : plus4
//   010  jtgt
//   011  {reg_target[MSB] & pc[MSB], reg_target[XLEN-2:0]}
//        jr can leave kernel mode but can never enter it.
//   100  ILLOP_VEC; epc <= plus4
//   101  XADR_VEC;  epc <= plus4
//   110  RAS return: if !ras_empty then pop and next_pc=ras_top, else next_pc=the 011 rule
//   111  hold (pc unchanged)
//  Stall: pc, epc and RAS all unchanged; irq is not taken and stays pending (level).
//  RAS push:
//   - Condition: link=1, pc_src in {010,011}, no stall, no irq taken.
//   - Action: entry[ptr]<=plus4, ptr<=ptr+1 mod RAS_DEPTH, count<=min(count+1, RAS_DEPTH).
//   - Overflow silently overwrites the oldest entry.
//  RAS pop: ptr<=ptr-1 mod RAS_DEPTH, count<=count-1.
//  Push and pop are mutually exclusive; link is ignored for all other codes.
//  ras_top=entry[ptr-1]; ras_empty=(count==0); both combinational from registered state.
//  Latency:
//   - Every selected PC appears on pc one cycle after the decision edge.
//   - plus4, kernel, ras_top and ras_empty are combinational from registers.
// TESTING
//  1. Reset low 2 cycles, then 3 cycles of pc_src=000 -> pc = 80000000, 80000004, 80000008, 8000000C; epc=0; ras_empty=1.
//  2. pc=00400000, pc_src=001, br_taken=1, ext_imm=FFFFFFFE -> pc=003FFFFC; same with br_taken=0 -> pc=00400004.
//  3. User mode pc=00400010, pc_src=011, reg_target=80001000 -> pc=00001000 (kernel bit blocked); kernel=0.
//  4. pc_src=010, link=1 at pc=00400000 then 00400100; two 110 returns -> pc=00400104 then 00400004; a third 110 with reg_target=00500000 -> pc=00500000.
//  5. RAS_DEPTH=4: push 5 calls, then pop 5 times -> last 4 return addresses come back in LIFO order; 5th pop uses reg_target.
//  6. irq=1 with stall=1 for 2 cycles at pc=00400020 -> pc held.
//     Then stall=0, pc_src=000 -> pc=80000004, epc=00400024.
//     Further irq is ignored while kernel=1.

Source files
------------

// File: rtl/pc_gen_ras.sv
// Program-counter unit: PC select with stall, kernel-mode protection, EPC capture
// on exceptions/interrupts, and a circular return-address stack for return prediction.
module pc_gen_ras #(
    parameter int unsigned      XLEN      = 32,
    parameter logic [XLEN-1:0]  RESET_PC  = 32'h8000_0000,
    parameter logic [XLEN-1:0]  ILLOP_VEC = 32'h8000_0004,
    parameter logic [XLEN-1:0]  XADR_VEC  = 32'h8000_0008,
    parameter int unsigned      RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic [2:0]      pc_src,
    input  logic            br_taken,
    input  logic [XLEN-1:0] ext_imm,
    input  logic [25:0]     jt,
    input  logic [XLEN-1:0] reg_target,
    input  logic            link,
    input  logic            irq,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] plus4,
    output logic [XLEN-1:0] epc,
    output logic [XLEN-1:0] ras_top,
    output logic            ras_empty,
    output logic            kernel
);

    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

    typedef enum logic [2:0] {
        SRC_PLUS4  = 3'b000,
        SRC_BRANCH = 3'b001,
        SRC_JUMP   = 3'b010,
        SRC_JR     = 3'b011,
        SRC_ILLOP  = 3'b100,
        SRC_XADR   = 3'b101,
        SRC_RET    = 3'b110,
        SRC_HOLD   = 3'b111
    } pc_src_e;

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_epc;
    logic [PW-1:0]   r_ptr;
    logic [CW-1:0]   r_count;
    logic [XLEN-1:0] r_ras [RAS_DEPTH];

    pc_src_e         w_src;
    logic [XLEN-1:0] w_plus4;
    logic [XLEN-1:0] w_sum;
    logic [XLEN-1:0] w_conba;
    logic [XLEN-1:0] w_jtgt;
    logic [XLEN-1:0] w_jr_pc;
    logic [XLEN-1:0] w_next_pc;
    logic [XLEN-1:0] w_ras_top;
    logic [PW-1:0]   w_top_idx;
    logic            w_ras_empty;
    logic            w_pop_req;
    logic            w_irq_take;
    logic            w_push;
    logic            w_pop;

    assign w_src       = pc_src_e'(pc_src);
    assign w_plus4     = {r_pc[XLEN-1], r_pc[XLEN-2:0] + (XLEN-1)'(4)};
    assign w_sum       = w_plus4 + {ext_imm[XLEN-3:0], 2'b00};
    assign w_conba     = {r_pc[XLEN-1], w_sum[XLEN-2:0]};
    // jr may drop the kernel bit but can only keep it if already in kernel mode
    assign w_jr_pc     = {reg_target[XLEN-1] & r_pc[XLEN-1], reg_target[XLEN-2:0]};
    assign w_top_idx   = r_ptr - 1'b1;
    assign w_ras_top   = r_ras[w_top_idx];
    assign w_ras_empty = (r_count == '0);

    always_comb begin
        w_jtgt = '0;
        w_jtgt[27:0] = {jt, 2'b00};
        w_jtgt[XLEN-1:XLEN-4] = r_pc[XLEN-1:XLEN-4];
    end

    always_comb begin
        w_next_pc = w_plus4;
        w_pop_req = 1'b0;
        unique case (w_src)
            SRC_PLUS4:  w_next_pc = w_plus4;
            SRC_BRANCH: w_next_pc = br_taken ? w_conba : w_plus4;
            SRC_JUMP:   w_next_pc = w_jtgt;
            SRC_JR:     w_next_pc = w_jr_pc;
            SRC_ILLOP:  w_next_pc = ILLOP_VEC;
            SRC_XADR:   w_next_pc = XADR_VEC;
            SRC_RET: begin
                if (!w_ras_empty) begin
                    w_next_pc = w_ras_top;
                    w_pop_req = 1'b1;
                end else begin
                    w_next_pc = w_jr_pc;
                end
            end
            SRC_HOLD:   w_next_pc = r_pc;
            default:    w_next_pc = w_plus4;
        endcase
    end

    assign w_irq_take = irq & ~stall & ~r_pc[XLEN-1];
    assign w_push     = link & ((w_src == SRC_JUMP) | (w_src == SRC_JR)) & ~stall & ~w_irq_take;
    assign w_pop      = w_pop_req & ~stall & ~w_irq_take;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc    <= RESET_PC;
            r_epc   <= '0;
            r_ptr   <= '0;
            r_count <= '0;
        end else if (!stall) begin
            if (w_irq_take) begin
                r_pc  <= ILLOP_VEC;
                r_epc <= w_next_pc;
            end else begin
                r_pc <= w_next_pc;
                if (w_src == SRC_ILLOP || w_src == SRC_XADR)
                    r_epc <= w_plus4;
                if (w_push) begin
                    r_ptr <= r_ptr + 1'b1;
                    if (r_count != CW'(RAS_DEPTH))
                        r_count <= r_count + 1'b1;
                end else if (w_pop) begin
                    r_ptr   <= r_ptr - 1'b1;
                    r_count <= r_count - 1'b1;
                end
            end
        end
    end

    // Entry storage carries no reset; validity is tracked by r_count alone
    always_ff @(posedge clk) begin
        if (reset && w_push)
            r_ras[r_ptr] <= w_plus4;
    end

    assign pc        = r_pc;
    assign plus4     = w_plus4;
    assign epc       = r_epc;
    assign ras_top   = w_ras_top;
    assign ras_empty = w_ras_empty;
    assign kernel    = r_pc[XLEN-1];

endmodule
